// File: rtl/lock_entry_ctrl.sv
// lock_entry_ctrl
//   Keypad lock sequencer. Debounce-free enter button is synchronised and
//   edge-detected into a one-cycle strobe; digits are shifted into an entry
//   register, compared against the stored code, and the result drives the
//   lock/unlock/error LEDs. Repeated failures trigger a timed lockout; while
//   open, the code can be reprogrammed from the keypad.
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   in_digit     keypad value: 0-9 digit, A-F clear key
//   enter_btn    asynchronous enter button (active-high level)
//   relock_btn   synchronous level, relock while open/programming
//   prog_req     synchronous level, start code change while open
//   locked_led   1 in IDLE/ENTRY/CHECK/ERROR/LOCKOUT
//   unlocked_led 1 in OPEN/PROG
//   error_led    1 in ERROR/LOCKOUT
//   state_leds   current state encoding
//   lockout      1 in LOCKOUT
module lock_entry_ctrl #(
    parameter int unsigned             CODE_LEN       = 4,
    parameter logic [4*CODE_LEN-1:0]   DEFAULT_CODE   = 16'h1234,
    parameter int unsigned             MAX_FAILS      = 3,
    parameter int unsigned             ERR_CYCLES     = 16,
    parameter int unsigned             LOCKOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] in_digit,
    input  logic       enter_btn,
    input  logic       relock_btn,
    input  logic       prog_req,
    output logic       locked_led,
    output logic       unlocked_led,
    output logic       error_led,
    output logic [2:0] state_leds,
    output logic       lockout
);

    localparam int unsigned CW   = 4 * CODE_LEN;
    localparam int unsigned IW   = $clog2(CODE_LEN + 1);
    localparam int unsigned TMAX = (ERR_CYCLES > LOCKOUT_CYCLES) ? ERR_CYCLES : LOCKOUT_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    localparam logic [IW-1:0] LAST_IDX   = IW'(CODE_LEN - 1);
    localparam logic [TW-1:0] ERR_LAST   = TW'(ERR_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LAST  = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0]    FAIL_LIMIT = 3'(MAX_FAILS);

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        ENTRY   = 3'b001,
        CHECK   = 3'b010,
        OPEN    = 3'b011,
        ERROR   = 3'b100,
        LOCKOUT = 3'b101,
        PROG    = 3'b110
    } state_t;

    state_t state_q, next_state;

    logic [CW-1:0] code;
    logic [CW-1:0] entry;
    logic [IW-1:0] digit_idx;
    logic [2:0]    fail_cnt;
    logic [TW-1:0] timer;

    logic sync1, sync2, sync3;
    logic enter_stb, is_digit, digit_stb, clear_stb;
    logic last_digit, entry_match;
    logic [CW-1:0] entry_shift;

    logic locked_d, unlocked_d, error_d, lockout_d;
    logic [2:0] state_leds_d;

    // Two flops resynchronise the button; the third holds the previous
    // synchronised level so a held button yields a single strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= enter_btn;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign enter_stb   = sync2 & ~sync3;
    assign is_digit    = (in_digit <= 4'd9);
    assign digit_stb   = enter_stb & is_digit;
    assign clear_stb   = enter_stb & ~is_digit;
    assign last_digit  = (digit_idx == LAST_IDX);
    assign entry_match = (entry == code);
    assign entry_shift = (entry << 4) | CW'(in_digit);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state_q;
        case (state_q)
            IDLE: begin
                // digit_idx is 0 here, so last_digit covers the single-digit code case
                if (digit_stb) begin
                    next_state = last_digit ? CHECK : ENTRY;
                end
            end
            ENTRY: begin
                if (clear_stb) begin
                    next_state = IDLE;
                end else if (digit_stb && last_digit) begin
                    next_state = CHECK;
                end
            end
            CHECK: begin
                if (entry_match) begin
                    next_state = OPEN;
                end else if ((fail_cnt + 3'd1) == FAIL_LIMIT) begin
                    next_state = LOCKOUT;
                end else begin
                    next_state = ERROR;
                end
            end
            ERROR: begin
                if (timer == ERR_LAST) begin
                    next_state = IDLE;
                end
            end
            LOCKOUT: begin
                if (timer == LOCK_LAST) begin
                    next_state = IDLE;
                end
            end
            OPEN: begin
                if (relock_btn) begin
                    next_state = IDLE;
                end else if (prog_req) begin
                    next_state = PROG;
                end
            end
            PROG: begin
                if (relock_btn) begin
                    next_state = IDLE;
                end else if (clear_stb) begin
                    next_state = OPEN;
                end else if (digit_stb && last_digit) begin
                    next_state = OPEN;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: entry shift register, digit index, stored code, fail count, timer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            code      <= DEFAULT_CODE;
            entry     <= '0;
            digit_idx <= '0;
            fail_cnt  <= '0;
            timer     <= '0;
        end else begin
            if (next_state != state_q) begin
                timer <= '0;
            end else if (state_q == ERROR || state_q == LOCKOUT) begin
                timer <= timer + TW'(1);
            end

            // Entry and index restart whenever a collecting phase begins or ends
            if (next_state != state_q &&
                (next_state == IDLE || next_state == OPEN || next_state == PROG)) begin
                entry     <= '0;
                digit_idx <= '0;
            end else if (digit_stb &&
                         (state_q == IDLE || state_q == ENTRY || state_q == PROG)) begin
                entry     <= entry_shift;
                digit_idx <= digit_idx + IW'(1);
            end

            if (state_q == PROG && !relock_btn && digit_stb && last_digit) begin
                code <= entry_shift;
            end

            if (state_q == CHECK) begin
                fail_cnt <= entry_match ? 3'd0 : fail_cnt + 3'd1;
            end else if (state_q == LOCKOUT && next_state == IDLE) begin
                fail_cnt <= '0;
            end
        end
    end

    // Output decode from the next state
    always_comb begin
        state_leds_d = next_state;
        unlocked_d   = (next_state == OPEN) || (next_state == PROG);
        locked_d     = ~unlocked_d;
        error_d      = (next_state == ERROR) || (next_state == LOCKOUT);
        lockout_d    = (next_state == LOCKOUT);
    end

    // Registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_leds   <= 3'b000;
            locked_led   <= 1'b1;
            unlocked_led <= 1'b0;
            error_led    <= 1'b0;
            lockout      <= 1'b0;
        end else begin
            state_leds   <= state_leds_d;
            locked_led   <= locked_d;
            unlocked_led <= unlocked_d;
            error_led    <= error_d;
            lockout      <= lockout_d;
        end
    end

endmodule

// File: tb/tb_lock_entry_ctrl.sv
// Testbench for lock_entry_ctrl with ERR_CYCLES=4, LOCKOUT_CYCLES=20.
module tb_lock_entry_ctrl;

    localparam logic [2:0] S_IDLE  = 3'b000;
    localparam logic [2:0] S_ENTRY = 3'b001;
    localparam logic [2:0] S_CHECK = 3'b010;
    localparam logic [2:0] S_OPEN  = 3'b011;
    localparam logic [2:0] S_ERROR = 3'b100;
    localparam logic [2:0] S_LOCK  = 3'b101;
    localparam logic [2:0] S_PROG  = 3'b110;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] in_digit = 4'd0;
    logic       enter_btn = 1'b0;
    logic       relock_btn = 1'b0;
    logic       prog_req = 1'b0;
    logic       locked_led, unlocked_led, error_led, lockout;
    logic [2:0] state_leds;

    int checks = 0;
    int failures = 0;

    lock_entry_ctrl #(
        .CODE_LEN       (4),
        .DEFAULT_CODE   (16'h1234),
        .MAX_FAILS      (3),
        .ERR_CYCLES     (4),
        .LOCKOUT_CYCLES (20)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_digit     (in_digit),
        .enter_btn    (enter_btn),
        .relock_btn   (relock_btn),
        .prog_req     (prog_req),
        .locked_led   (locked_led),
        .unlocked_led (unlocked_led),
        .error_led    (error_led),
        .state_leds   (state_leds),
        .lockout      (lockout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string      name;
        logic [2:0] st;
    } exp_t;

    typedef enum int {OP_PRESS, OP_WAIT, OP_RELOCK, OP_PROG, OP_BOTH} op_t;

    typedef struct {
        op_t        op;
        int         arg;
        logic [2:0] st;
        string      name;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    // Expected LED pattern for a given state
    function automatic logic [6:0] decode(input logic [2:0] st);
        logic lk, ul, er, lo;
        ul = (st == S_OPEN) || (st == S_PROG);
        lk = ~ul;
        er = (st == S_ERROR) || (st == S_LOCK);
        lo = (st == S_LOCK);
        return {st, lk, ul, er, lo};
    endfunction

    task automatic expect_state(input string name, input logic [2:0] st);
        exp_t e;
        e.name = name;
        e.st   = st;
        sb.push_back(e);
    endtask

    task automatic compare();
        exp_t e;
        logic [6:0] act, req;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: no expectation queued");
            return;
        end
        e   = sb.pop_front();
        act = {state_leds, locked_led, unlocked_led, error_led, lockout};
        req = decode(e.st);
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got state=%b lk/ul/er/lo=%b, required state=%b lk/ul/er/lo=%b",
                     e.name, act[6:4], act[3:0], req[6:4], req[3:0]);
        end
    endtask

    // Called at a negedge; returns at the negedge after the strobe's edge.
    task automatic press(input logic [3:0] d);
        enter_btn = 1'b0;
        repeat (2) @(negedge clk);
        in_digit  = d;
        enter_btn = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        enter_btn = 1'b0;
    endtask

    task automatic pulse(input logic r, input logic p);
        relock_btn = r;
        prog_req   = p;
        @(negedge clk);
        relock_btn = 1'b0;
        prog_req   = 1'b0;
    endtask

    task automatic run(input op_t op, input int arg, input logic [2:0] st, input string name);
        expect_state(name, st);
        case (op)
            OP_PRESS:  press(4'(arg));
            OP_WAIT:   repeat (arg) @(negedge clk);
            OP_RELOCK: pulse(1'b1, 1'b0);
            OP_PROG:   pulse(1'b0, 1'b1);
            OP_BOTH:   pulse(1'b1, 1'b1);
            default:   ;
        endcase
        compare();
    endtask

    function automatic void add(input op_t op, input int arg, input logic [2:0] st, input string name);
        vec_t v;
        v.op = op; v.arg = arg; v.st = st; v.name = name;
        vecs.push_back(v);
    endfunction

    // Enter a 4-digit code; expect CHECK then final_st one cycle later
    task automatic enter_code(input logic [15:0] c, input logic [2:0] final_st, input string name);
        logic [15:0] cc;
        cc = c;
        for (int i = 0; i < 3; i++) run(OP_PRESS, int'(cc[15-4*i -: 4]), S_ENTRY, name);
        run(OP_PRESS, int'(cc[3:0]), S_CHECK, name);
        run(OP_WAIT, 1, final_st, name);
        if (final_st == S_ERROR) run(OP_WAIT, 4, S_IDLE, {name, "_err_done"});
    endtask

    initial begin
        // Main table
        add(OP_PRESS, 1, S_ENTRY, "first_digit");
        add(OP_PRESS, 2, S_ENTRY, "digit2");
        add(OP_PRESS, 3, S_ENTRY, "digit3");
        add(OP_PRESS, 4, S_CHECK, "check_after_4th");
        add(OP_WAIT,  1, S_OPEN,  "open_1234");
        add(OP_PRESS, 5, S_OPEN,  "open_ignores_strobe");
        add(OP_RELOCK, 0, S_IDLE, "relock");
        add(OP_PRESS, 10, S_IDLE, "clear_in_idle");
        add(OP_PRESS, 1, S_ENTRY, "e1");
        add(OP_PRESS, 2, S_ENTRY, "e2");
        add(OP_PRESS, 11, S_IDLE, "clear_in_entry");
        add(OP_PRESS, 1, S_ENTRY, "w1");
        add(OP_PRESS, 2, S_ENTRY, "w2");
        add(OP_PRESS, 3, S_ENTRY, "w3");
        add(OP_PRESS, 5, S_CHECK, "w_check");
        add(OP_WAIT,  1, S_ERROR, "error_first");
        add(OP_WAIT,  3, S_ERROR, "error_fourth_cycle");
        add(OP_WAIT,  1, S_IDLE,  "error_done");
        add(OP_PRESS, 1, S_ENTRY, "c1");
        add(OP_PRESS, 2, S_ENTRY, "c2");
        add(OP_PRESS, 3, S_ENTRY, "c3");
        add(OP_PRESS, 4, S_CHECK, "c_check");
        add(OP_WAIT,  1, S_OPEN,  "open_after_error");
        add(OP_PROG,  0, S_PROG,  "enter_prog");
        add(OP_PRESS, 9, S_PROG,  "p9");
        add(OP_PRESS, 8, S_PROG,  "p8");
        add(OP_PRESS, 7, S_PROG,  "p7");
        add(OP_PRESS, 6, S_OPEN,  "prog_done");
        add(OP_RELOCK, 0, S_IDLE, "relock_after_prog");
        add(OP_PRESS, 1, S_ENTRY, "o1");
        add(OP_PRESS, 2, S_ENTRY, "o2");
        add(OP_PRESS, 3, S_ENTRY, "o3");
        add(OP_PRESS, 4, S_CHECK, "o_check");
        add(OP_WAIT,  1, S_ERROR, "old_code_fails");
        add(OP_WAIT,  4, S_IDLE,  "old_err_done");
        add(OP_PRESS, 9, S_ENTRY, "n9");
        add(OP_PRESS, 8, S_ENTRY, "n8");
        add(OP_PRESS, 7, S_ENTRY, "n7");
        add(OP_PRESS, 6, S_CHECK, "n_check");
        add(OP_WAIT,  1, S_OPEN,  "new_code_opens");
        add(OP_PROG,  0, S_PROG,  "prog2");
        add(OP_PRESS, 5, S_PROG,  "q5");
        add(OP_PRESS, 12, S_OPEN, "prog_clear");
        add(OP_BOTH,  0, S_IDLE,  "relock_and_prog");
        add(OP_PRESS, 9, S_ENTRY, "k9");
        add(OP_PRESS, 8, S_ENTRY, "k8");
        add(OP_PRESS, 7, S_ENTRY, "k7");
        add(OP_PRESS, 6, S_CHECK, "k_check");
        add(OP_WAIT,  1, S_OPEN,  "code_kept_after_clear");
        add(OP_PROG,  0, S_PROG,  "prog3");
        add(OP_PRESS, 1, S_PROG,  "r1");
        add(OP_RELOCK, 0, S_IDLE, "prog_relock");
        add(OP_PRESS, 9, S_ENTRY, "m9");
        add(OP_PRESS, 8, S_ENTRY, "m8");
        add(OP_PRESS, 7, S_ENTRY, "m7");
        add(OP_PRESS, 6, S_CHECK, "m_check");
        add(OP_WAIT,  1, S_OPEN,  "code_kept_after_relock");
        add(OP_RELOCK, 0, S_IDLE, "relock3");

        repeat (2) @(negedge clk);
        expect_state("reset_state", S_IDLE);
        compare();
        reset = 1'b0;

        foreach (vecs[i]) run(vecs[i].op, vecs[i].arg, vecs[i].st, vecs[i].name);

        // Reset mid-ENTRY: outputs return immediately, code reverts to default
        run(OP_PRESS, 1, S_ENTRY, "pre_reset_entry");
        #2 reset = 1'b1;
        #1 expect_state("reset_mid_entry", S_IDLE);
        compare();
        @(negedge clk);
        reset = 1'b0;
        enter_code(16'h1234, S_OPEN, "default_after_reset");
        run(OP_RELOCK, 0, S_IDLE, "relock4");

        // Held button gives one digit only
        in_digit  = 4'd1;
        enter_btn = 1'b1;
        repeat (50) @(negedge clk);
        enter_btn = 1'b0;
        expect_state("hold_one_digit", S_ENTRY);
        compare();
        run(OP_PRESS, 2, S_ENTRY, "hold_d2");
        run(OP_PRESS, 3, S_ENTRY, "hold_no_repeat");
        run(OP_PRESS, 4, S_CHECK, "hold_check");
        run(OP_WAIT,  1, S_OPEN,  "hold_open");
        run(OP_RELOCK, 0, S_IDLE, "relock5");

        // Lockout: the clear in between must not touch the fail count
        enter_code(16'h1111, S_ERROR, "wrong1");
        run(OP_PRESS, 1, S_ENTRY, "lc1");
        run(OP_PRESS, 2, S_ENTRY, "lc2");
        run(OP_PRESS, 10, S_IDLE, "lc_clear");
        enter_code(16'h1111, S_ERROR, "wrong2");
        enter_code(16'h1111, S_LOCK, "lockout_enter");
        in_digit = 4'd1;
        for (int i = 0; i < 19; i++) begin
            enter_btn = (i < 12) && ((i % 4) < 2);
            expect_state("lockout_hold", S_LOCK);
            @(negedge clk);
            compare();
        end
        enter_btn = 1'b0;
        expect_state("lockout_exit", S_IDLE);
        @(negedge clk);
        compare();
        enter_code(16'h1111, S_ERROR, "fail_cnt_cleared");
        enter_code(16'h1234, S_OPEN, "open_after_lockout");
        run(OP_RELOCK, 0, S_IDLE, "relock6");

        // Reset mid-LOCKOUT
        enter_code(16'h2222, S_ERROR, "wrong_a");
        enter_code(16'h2222, S_ERROR, "wrong_b");
        enter_code(16'h2222, S_LOCK, "lockout_again");
        run(OP_WAIT, 5, S_LOCK, "lockout_mid");
        #2 reset = 1'b1;
        #1 expect_state("reset_mid_lockout", S_IDLE);
        compare();
        @(negedge clk);
        reset = 1'b0;
        run(OP_WAIT, 2, S_IDLE, "idle_after_reset");
        enter_code(16'h1234, S_OPEN, "open_after_lockout_reset");

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover: %0d entries, required 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
